// File: rtl/fifo_sync.sv
// Synchronous single-clock FIFO with level flags, sticky error flags and registered or FWFT read port.
// Latency: registered mode presents a popped word one cycle after the accepted read; FWFT mode shows a word written to an empty FIFO one cycle after the write.
// Backpressure: writes are dropped while wfull (sets overflow), reads are ignored while rempty (sets underflow).
module fifo_sync #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] write_data,
    input  logic             wq,
    input  logic             rq,
    input  logic             err_clr,
    output logic [DSIZE-1:0] read_data,
    output logic             rvalid,
    output logic             wfull,
    output logic             rempty,
    output logic             afull,
    output logic             aempty,
    output logic [ASIZE:0]   wcount,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_afull_range
        $error("fifo_sync: AFULL_TH must lie in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_aempty_range
        $error("fifo_sync: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   count_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // Flags are gated on the registered state, so an empty FIFO never bypasses
    // a same-cycle write to the reader and a full FIFO never takes a write.
    assign wr_acc    = wq & ~wfull;
    assign rd_acc    = rq & ~rempty;
    assign wcount    = wptr - rptr;
    assign count_nxt = wcount + (ASIZE+1)'(wr_acc) - (ASIZE+1)'(rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr[ASIZE-1:0]] <= write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfull  <= 1'b0;
            rempty <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            wfull  <= (count_nxt == DEPTH_C);
            rempty <= (count_nxt == '0);
            afull  <= (count_nxt >= AFULL_C);
            aempty <= (count_nxt <= AEMPTY_C);
        end
    end

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wq & wfull)  | (overflow  & ~err_clr);
            underflow <= (rq & rempty) | (underflow & ~err_clr);
        end
    end

    if (FWFT == 0) begin : g_reg_read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid    <= 1'b0;
                read_data <= '0;
            end else begin
                rvalid <= rd_acc;
                if (rd_acc) read_data <= mem[rptr[ASIZE-1:0]];
            end
        end
    end else begin : g_fwft_read
        logic [ASIZE:0] remain;
        logic [ASIZE:0] rptr_nxt;

        assign remain   = wcount - (ASIZE+1)'(rd_acc);
        assign rptr_nxt = rptr + (ASIZE+1)'(rd_acc);
        assign rvalid   = ~rempty;

        // Head register is preloaded with the word that will be oldest after
        // this edge; when nothing older survives, it takes the incoming write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                read_data <= '0;
            end else if (remain != '0) begin
                read_data <= mem[rptr_nxt[ASIZE-1:0]];
            end else if (wr_acc) begin
                read_data <= write_data;
            end
        end
    end

endmodule
